cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/breakpoint controller for the pipelined RISC-V DataPath on the board top level.
//  Turns two raw push-buttons into one clock-enable (cpu_en), so the CPU can halt, single-step,
//  burst-step N cycles or free-run. In RUN and BURST a fetch-PC breakpoint can stop it.
//  Status (halted, bp_hit, state, cycle_count) feeds the LED/SSD select muxes.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  cycles a synced button level must stay stable before it is accepted
//  PC_W             32         width of pc / bp_addr
//  CNT_W            16         width of cycle_count (saturating)
// PORTS
//  clk          in   1      system clock; the only clock
//  rst          in   1      reset, synchronous, active-high
//  btn_step     in   1      raw step button (asynchronous, bouncing)
//  btn_run      in   1      raw run/stop toggle button (asynchronous, bouncing)
//  burst_len    in   8      cycles per step press; 0 and 1 both mean a single cycle
//  bp_en        in   1      breakpoint enable
//  bp_addr      in   PC_W   breakpoint fetch address
//  pc           in   PC_W   current fetch PC from DataPath
//  cpu_en       out  1      DataPath clock-enable (combinational from state regs and pc)
//  halted       out  1      1 in IDLE or BREAK
//  bp_hit       out  1      1 in BREAK
//  state_o      out  3      encoded FSM state
//  cycle_count  out  CNT_W  number of cycles with cpu_en=1; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, remaining=0, skip=0, cycle_count=0; debouncers cleared.
//   While rst=1: cpu_en=0, halted=1, bp_hit=0.
//  Button front end: 2-FF synchroniser, then stability counter, then rising-edge detect.
//   Output is a 1-cycle pulse (step_p / run_p). It rises on the (DEBOUNCE_CYCLES+3)th edge
//   after the raw input goes high and stays high. Glitches shorter than DEBOUNCE_CYCLES are ignored.
//   Release produces no pulse.
//  FSM states: IDLE, STEP, BURST, RUN, BREAK.
//   IDLE : run_p -> RUN. step_p -> STEP if burst_len<=1; else BURST with remaining<=burst_len.
//   STEP : cpu_en=1 for exactly one cycle, then IDLE.
//   BURST: cpu_en=1 each cycle and remaining decrements. When remaining==1 and enabled -> IDLE.
//          burst_len is sampled only at entry. run_p aborts -> IDLE (cpu_en=0 in the abort cycle).
//          step_p is ignored.
//   RUN  : cpu_en=1. run_p -> IDLE. step_p is ignored.
//   BREAK: cpu_en=0. run_p -> RUN with skip=1. step_p -> STEP/BURST as from IDLE, with skip=1.
//  run_p and step_p in the same cycle: run_p wins and step_p is dropped.
//  Breakpoint: bp_match = bp_en & (pc==bp_addr) & ~skip, evaluated in RUN and BURST only.
//   On match, cpu_en=0 in that same cycle (the instruction at bp_addr is not advanced).
//   Next state is BREAK and remaining is cleared.
//   skip clears after the first cycle with cpu_en=1, so resuming runs past the breakpoint once.
//   STEP ignores breakpoints.
//  cycle_count: +1 on each clk edge where cpu_en=1; holds at 2^CNT_W-1; cleared only by rst.
//  Reset mid-RUN/BURST: cpu_en drops in the cycle rst is high; the FSM restarts in IDLE.
//  All registers are updated on posedge clk only; no latches; no gated clocks.
// STRUCTURE
//  Shared package run_ctrl_pkg: state encoding localparams
//   (IDLE=0, STEP=1, BURST=2, RUN=3, BREAK=4) and the BURST_W=8 constant.
//   The LED/SSD mux logic decodes state_o through this package.
//  Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, btn_raw, press_pulse).
//   Instantiated twice.
//  Top level of the block: FSM, remaining counter, skip flag, bp comparator, cycle_count.
// TESTING  (DEBOUNCE_CYCLES=4 in simulation)
//  1 rst held 3 cycles, then released -> cpu_en=0, halted=1, state_o=0, cycle_count=0.
//  2 burst_len=1, btn_step high 10 cycles (bounce 1-cycle glitch first)
//    -> exactly one cpu_en cycle; cycle_count=1; no pulse from the glitch.
//  3 burst_len=5, step press -> cpu_en high exactly 5 consecutive cycles, then IDLE;
//    changing burst_len to 2 mid-burst has no effect; cycle_count=5.
//  4 bp_en=1, bp_addr=0x10, run press, pc steps 0x0,0x4,0x8,0xC,0x10
//    -> cpu_en=0 in the cycle pc=0x10; state_o=BREAK; bp_hit=1.
//    Then run press -> cpu_en=1 with pc=0x10 and execution continues.
//  5 run and step pressed on the same edge from IDLE -> RUN, no burst;
//    second run press -> IDLE; a step press during RUN is ignored.
//  6 rst asserted during BURST (remaining=3) -> cpu_en=0 that cycle;
//    then IDLE with cycle_count=0; a new step press behaves as in test 3.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : run_ctrl_pkg
// Brief   : Shared state encoding and constants for the CPU run/step controller.
//           The LED/SSD select muxes decode state_o through these definitions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package run_ctrl_pkg;

  // Width of the burst length input and the remaining-cycles counter
  localparam int BURST_W = 8;

  // Encoded controller states as presented on state_o
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_STEP  = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    STEP  = ST_STEP,
    BURST = ST_BURST,
    RUN   = ST_RUN,
    BREAK = ST_BREAK
  } run_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// Module  : btn_debounce
// Brief   : Push-button front end: 2-FF synchroniser, stability counter and
//           rising-edge detector producing a single-cycle press pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);

  // Counter wide enough to reach DEBOUNCE_CYCLES-1 (at least one bit)
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;
  logic          level;
  logic          level_d;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync2 != level) begin
      if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  // Registered rising-edge detect: one pulse per accepted press, none on release
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      level_d     <= level;
      press_pulse <= level & ~level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
//------------------------------------------------------------------------------
// Module  : cpu_run_ctrl
// Brief   : Run/step/burst/breakpoint controller generating the DataPath
//           clock-enable from two debounced push-buttons.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PC_W            = 32,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_step,
  input  logic               btn_run,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  output logic               cpu_en,
  output logic               halted,
  output logic               bp_hit,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   cycle_count
);

  run_state_t         state;
  logic [BURST_W-1:0] remaining;
  logic               skip;
  logic               step_p;
  logic               run_p;
  logic               bp_match;
  logic               from_break;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_step),
    .press_pulse (step_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_run),
    .press_pulse (run_p)
  );

  // Breakpoint compare, only live while free-running or bursting; skip lets a
  // resume step over the address it stopped on
  always_comb begin
    bp_match = bp_en && (pc == bp_addr) && !skip && ((state == RUN) || (state == BURST));
  end

  // Clock-enable: a breakpoint hit or a burst abort holds the DataPath in the same cycle
  always_comb begin
    cpu_en = 1'b0;
    if (!rst) begin
      case (state)
        STEP:    cpu_en = 1'b1;
        BURST:   cpu_en = !run_p && !bp_match;
        RUN:     cpu_en = !bp_match;
        default: cpu_en = 1'b0;
      endcase
    end
  end

  // Status decode; reset forces the halted view while the state register catches up
  always_comb begin
    halted     = rst || (state == IDLE) || (state == BREAK);
    bp_hit     = !rst && (state == BREAK);
    state_o    = state;
    from_break = (state == BREAK);
  end

  // Controller FSM with burst counter, breakpoint skip flag and cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      skip        <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (cpu_en && (cycle_count != {CNT_W{1'b1}})) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (cpu_en) begin
        skip <= 1'b0;
      end

      case (state)
        IDLE, BREAK: begin
          // run wins when both buttons pulse together
          if (run_p) begin
            state <= RUN;
            skip  <= from_break;
          end else if (step_p) begin
            if (burst_len <= BURST_W'(1)) begin
              state <= STEP;
            end else begin
              state     <= BURST;
              remaining <= burst_len;
            end
            skip <= from_break;
          end
        end

        STEP: begin
          state <= IDLE;
        end

        BURST: begin
          if (run_p) begin
            state     <= IDLE;
            remaining <= '0;
          end else if (bp_match) begin
            state     <= BREAK;
            remaining <= '0;
          end else if (remaining == BURST_W'(1)) begin
            state     <= IDLE;
            remaining <= '0;
          end else begin
            remaining <= remaining - 1'b1;
          end
        end

        RUN: begin
          if (run_p) begin
            state <= IDLE;
          end else if (bp_match) begin
            state     <= BREAK;
            remaining <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
